uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

UART transmit serializer: accepts a parallel data word over a valid/ready handshake and shifts it out on a single serial line as start bit, LSB-first data, optional parity bit and one or two stop bits. Sits directly downstream of `uart_parity_gen`, which it instantiates to produce the parity bit. Feeds the pad-side TX line of the UART.

## Interface
Parameters:
- `DATA_BITS`, 8: data word width, legal range 5..9.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit, ≥ 2.

Ports:
- `clk` in 1: single clock for the whole block.
- `rst` in 1: reset, synchronous and active-high.
- `tx_data` in DATA_BITS: word to send, sampled at acceptance.
- `tx_valid` in 1: `tx_data` and config are valid.
- `tx_ready` out 1: block can accept a word.
- `parity_en` in 1: 1 = insert parity bit; sampled at acceptance.
- `parity_even_n` in 1: 0 = even parity, 1 = odd parity; sampled at acceptance.
- `stop2` in 1: 1 = two stop bits, 0 = one; sampled at acceptance.
- `tx` out 1: serial line, idle high, registered.
- `busy` out 1: frame in progress; equals `~tx_ready`.

## Operation
- Reset values: `tx`=1, `tx_ready`=1, `busy`=0, state IDLE, counters 0.
- Acceptance: rising edge where `tx_valid & tx_ready` are both high. At that edge, latch `tx_data`, `parity_en`, `parity_even_n`, `stop2` and the parity bit. Go to START. Drive `tx`=0 and `tx_ready`=0.
- `tx_valid` while `tx_ready`=0 is ignored. Nothing is queued. Config input changes mid-frame have no effect.
- States and transitions:
  - IDLE → START on acceptance.
  - START → DATA after one bit period.
  - DATA → PARITY after DATA_BITS bit periods, if `parity_en`; otherwise → STOP.
  - PARITY → STOP after one bit period.
  - STOP → IDLE after 1 or 2 bit periods, per `stop2`.
- Data bits go out LSB first, using a bit index of width $clog2(DATA_BITS).
- Parity is computed by `uart_parity_gen` over the latched word. Even mode gives the XOR of the data bits. Odd mode gives its complement.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary.
  - Resets to 0 on acceptance.
- `tx` is always driven from a register, never from combinational logic.

## Timing
- Let E0 be the accepting edge. Bit n (start = 0) is on `tx` from edge E0+n·CLKS_PER_BIT for exactly CLKS_PER_BIT cycles.
- Frame length N·CLKS_PER_BIT cycles, with N = 1 + DATA_BITS + parity_en + (stop2 ? 2 : 1).
- At edge E0+N·CLKS_PER_BIT: state → IDLE, `tx_ready`=1, `tx` stays 1.
- Earliest next acceptance is the following edge. Back-to-back frames therefore have exactly one idle-high cycle between the last stop bit and the next start bit.
- Reset mid-frame: at the reset edge, `tx`=1, `tx_ready`=1, the frame is abandoned and nothing is retransmitted. Reset takes priority over a simultaneous `tx_valid`.

## Structure
- Shared package `uart_pkg`:
  - state encoding constants for IDLE, START, DATA, PARITY, STOP;
  - a `PARITY_EVEN`/`PARITY_ODD` constant pair, shared with the receiver.
- One sub-module: `uart_parity_gen` with WIDTH = DATA_BITS, fed from the data holding register.
- Remaining logic is a single FSM plus baud and bit counters, with no further hierarchy.

## Test plan
All scenarios use DATA_BITS=8, CLKS_PER_BIT=4.
1. Send 0xA5, parity off, one stop bit → `tx` runs 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. `tx_ready` rises at E0+40.
2. Send 0xA5 with parity on:
   - `parity_even_n`=0 → parity bit 0.
   - `parity_even_n`=1 → parity bit 1.
   - Frame length 44 cycles in both cases.
3. Send 0x07, odd parity, two stop bits → parity bit 0. Stop bits high for 8 cycles. `tx_ready` rises at E0+48.
4. Hold `tx_valid` high with 0x00 then 0xFF → two correct frames separated by exactly one idle-high cycle. Second acceptance at E0+41.
5. Assert `rst` during data bit 3 of 0x3C → next cycle `tx`=1, `tx_ready`=1. A following 0x81 frame is bit-exact.
6. Toggle `parity_en`, `stop2` and `tx_data` mid-frame with `tx_valid` high → the current frame is unchanged and no extra acceptance occurs before `tx_ready` rises.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit/receive FSM state encoding and parity mode constants.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Parity mode select, as carried on parity_even_n.
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_parity_gen.sv
// Combinational parity over a data word; odd mode returns the complement of the XOR reduction.
module uart_parity_gen
  import uart_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             mode,
  output logic             parity
);

  assign parity = (^data) ^ (mode == PARITY_ODD);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, one or two stop bits.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 parity_en,
  input  logic                 parity_even_n,
  input  logic                 stop2,
  output logic                 tx,
  output logic                 busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  uart_state_t          state, state_nxt;
  logic [BAUD_W-1:0]    baud_cnt, baud_nxt;
  logic [BIT_W-1:0]     bit_idx, bit_nxt, bit_inc;
  logic                 tx_nxt;
  logic                 accept;
  logic                 bit_end;
  logic                 parity_bit;

  logic [DATA_BITS-1:0] data_q;
  logic                 par_en_q;
  logic                 par_mode_q;
  logic                 stop2_q;

  assign tx_ready = (state == ST_IDLE);
  assign busy     = ~tx_ready;
  assign accept   = tx_valid & tx_ready;
  assign bit_end  = (baud_cnt == BAUD_LAST);
  assign bit_inc  = bit_idx + 1'b1;

  uart_parity_gen #(
    .WIDTH (DATA_BITS)
  ) u_parity (
    .data   (data_q),
    .mode   (par_mode_q),
    .parity (parity_bit)
  );

  // Frame holding registers: loaded only at acceptance, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_q     <= tx_data;
      par_en_q   <= parity_en;
      par_mode_q <= parity_even_n;
      stop2_q    <= stop2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      tx       <= tx_nxt;
    end
  end

  // tx_nxt is the level for the next cycle, so tx changes on the same edge as the state.
  always_comb begin
    state_nxt = state;
    baud_nxt  = bit_end ? '0 : baud_cnt + 1'b1;
    bit_nxt   = bit_idx;
    tx_nxt    = tx;
    case (state)
      ST_IDLE: begin
        baud_nxt = '0;
        bit_nxt  = '0;
        tx_nxt   = 1'b1;
        if (accept) begin
          state_nxt = ST_START;
          tx_nxt    = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_nxt = ST_DATA;
          bit_nxt   = '0;
          tx_nxt    = data_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx == BIT_LAST) begin
            bit_nxt = '0;
            if (par_en_q) begin
              state_nxt = ST_PARITY;
              tx_nxt    = parity_bit;
            end else begin
              state_nxt = ST_STOP;
              tx_nxt    = 1'b1;
            end
          end else begin
            bit_nxt = bit_inc;
            tx_nxt  = data_q[bit_inc];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_nxt = ST_STOP;
          bit_nxt   = '0;
          tx_nxt    = 1'b1;
        end
      end
      ST_STOP: begin
        tx_nxt = 1'b1;
        if (bit_end) begin
          // bit_idx counts stop bits already sent within this state.
          if (stop2_q && (bit_idx == '0)) begin
            bit_nxt = bit_inc;
          end else begin
            state_nxt = ST_IDLE;
            bit_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        baud_nxt  = '0;
        bit_nxt   = '0;
        tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with DATA_BITS=8, CLKS_PER_BIT=4.
module tb_uart_tx_serializer;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       parity_en;
  logic       parity_even_n;
  logic       stop2;
  logic       tx;
  logic       busy;

  int tests = 0;
  int fails = 0;

  uart_tx_serializer #(
    .DATA_BITS    (8),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .parity_en     (parity_en),
    .parity_even_n (parity_even_n),
    .stop2         (stop2),
    .tx            (tx),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: tx=%b ready=%b busy=%b, expected tx=1 ready=1 busy=0", tx, tx_ready, busy);
    end
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(negedge clk);
    tests++;
    if (tx !== 1'b1 || tx_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_priority: tx=%b ready=%b, expected tx=1 ready=1", tx, tx_ready);
    end
    tx_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    tests++;
    if (tx !== 1'b1 || tx_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_idle: tx=%b ready=%b, expected tx=1 ready=1", tx, tx_ready);
    end
  endtask

  task automatic test_basic();
    logic [15:0] f;
    f = {6'b0, 1'b1, 8'hA5, 1'b0};
    @(negedge clk);
    tx_data = 8'hA5; parity_en = 1'b0; parity_even_n = 1'b0; stop2 = 1'b0; tx_valid = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 10 * CPB; c++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      tests++;
      if (tx !== f[c / CPB] || tx_ready !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL basic_frame cycle %0d: tx=%b ready=%b busy=%b, expected tx=%b ready=0 busy=1", c, tx, tx_ready, busy, f[c / CPB]);
      end
    end
    @(negedge clk);
    tests++;
    if (tx_ready !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
      fails++;
      $display("FAIL basic_done: ready=%b busy=%b tx=%b, expected 1 0 1", tx_ready, busy, tx);
    end
  endtask

  task automatic test_parity();
    logic [15:0] f;
    for (int m = 0; m < 2; m++) begin
      // 0xA5 has four ones: even parity 0, odd parity 1.
      f = {5'b0, 1'b1, m[0], 8'hA5, 1'b0};
      @(negedge clk);
      tx_data = 8'hA5; parity_en = 1'b1; parity_even_n = m[0]; stop2 = 1'b0; tx_valid = 1'b1;
      @(posedge clk);
      for (int c = 0; c < 11 * CPB; c++) begin
        @(negedge clk);
        tx_valid = 1'b0;
        tests++;
        if (tx !== f[c / CPB] || tx_ready !== 1'b0) begin
          fails++;
          $display("FAIL parity_frame mode %0d cycle %0d: tx=%b ready=%b, expected tx=%b ready=0", m, c, tx, tx_ready, f[c / CPB]);
        end
      end
      @(negedge clk);
      tests++;
      if (tx_ready !== 1'b1 || tx !== 1'b1) begin
        fails++;
        $display("FAIL parity_done mode %0d: ready=%b tx=%b, expected 1 1", m, tx_ready, tx);
      end
    end
    parity_en = 1'b0; parity_even_n = 1'b0;
  endtask

  task automatic test_two_stop();
    logic [15:0] f;
    // 0x07 has three ones: odd parity 0.
    f = {4'b0, 2'b11, 1'b0, 8'h07, 1'b0};
    @(negedge clk);
    tx_data = 8'h07; parity_en = 1'b1; parity_even_n = 1'b1; stop2 = 1'b1; tx_valid = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 12 * CPB; c++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      tests++;
      if (tx !== f[c / CPB] || tx_ready !== 1'b0) begin
        fails++;
        $display("FAIL two_stop_frame cycle %0d: tx=%b ready=%b, expected tx=%b ready=0", c, tx, tx_ready, f[c / CPB]);
      end
    end
    @(negedge clk);
    tests++;
    if (tx_ready !== 1'b1 || tx !== 1'b1) begin
      fails++;
      $display("FAIL two_stop_done: ready=%b tx=%b, expected 1 1", tx_ready, tx);
    end
    parity_en = 1'b0; parity_even_n = 1'b0; stop2 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] f0, f1;
    f0 = {6'b0, 1'b1, 8'h00, 1'b0};
    f1 = {6'b0, 1'b1, 8'hFF, 1'b0};
    @(negedge clk);
    tx_data = 8'h00; tx_valid = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 10 * CPB; c++) begin
      @(negedge clk);
      tx_data = 8'hFF;
      tests++;
      if (tx !== f0[c / CPB] || tx_ready !== 1'b0) begin
        fails++;
        $display("FAIL b2b_first cycle %0d: tx=%b ready=%b, expected tx=%b ready=0", c, tx, tx_ready, f0[c / CPB]);
      end
    end
    @(negedge clk);
    tests++;
    if (tx_ready !== 1'b1 || tx !== 1'b1) begin
      fails++;
      $display("FAIL b2b_idle_gap: ready=%b tx=%b, expected 1 1", tx_ready, tx);
    end
    @(posedge clk);
    for (int c = 0; c < 10 * CPB; c++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      tests++;
      if (tx !== f1[c / CPB] || tx_ready !== 1'b0) begin
        fails++;
        $display("FAIL b2b_second cycle %0d: tx=%b ready=%b, expected tx=%b ready=0", c, tx, tx_ready, f1[c / CPB]);
      end
    end
    @(negedge clk);
    tests++;
    if (tx_ready !== 1'b1 || tx !== 1'b1) begin
      fails++;
      $display("FAIL b2b_done: ready=%b tx=%b, expected 1 1", tx_ready, tx);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] f0, f1;
    f0 = {6'b0, 1'b1, 8'h3C, 1'b0};
    f1 = {6'b0, 1'b1, 8'h81, 1'b0};
    @(negedge clk);
    tx_data = 8'h3C; tx_valid = 1'b1;
    @(posedge clk);
    // Data bit 3 occupies frame slot 4, cycles 16..19.
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      tests++;
      if (tx !== f0[c / CPB] || tx_ready !== 1'b0) begin
        fails++;
        $display("FAIL rst_mid_pre cycle %0d: tx=%b ready=%b, expected tx=%b ready=0", c, tx, tx_ready, f0[c / CPB]);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_abort: tx=%b ready=%b busy=%b, expected 1 1 0", tx, tx_ready, busy);
    end
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      tests++;
      if (tx !== 1'b1 || tx_ready !== 1'b1) begin
        fails++;
        $display("FAIL rst_mid_no_retx cycle %0d: tx=%b ready=%b, expected 1 1", c, tx, tx_ready);
      end
    end
    tx_data = 8'h81; tx_valid = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 10 * CPB; c++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      tests++;
      if (tx !== f1[c / CPB] || tx_ready !== 1'b0) begin
        fails++;
        $display("FAIL rst_mid_next cycle %0d: tx=%b ready=%b, expected tx=%b ready=0", c, tx, tx_ready, f1[c / CPB]);
      end
    end
    @(negedge clk);
    tests++;
    if (tx_ready !== 1'b1 || tx !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_next_done: ready=%b tx=%b, expected 1 1", tx_ready, tx);
    end
  endtask

  task automatic test_config_change();
    logic [15:0] f;
    f = {6'b0, 1'b1, 8'hA5, 1'b0};
    @(negedge clk);
    tx_data = 8'hA5; parity_en = 1'b0; parity_even_n = 1'b0; stop2 = 1'b0; tx_valid = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 10 * CPB; c++) begin
      @(negedge clk);
      if (c == 5)  parity_en = 1'b1;
      if (c == 13) begin stop2 = 1'b1; tx_data = 8'h5A; end
      if (c == 30) parity_even_n = 1'b1;
      if (c == 10 * CPB - 1) tx_valid = 1'b0;
      tests++;
      if (tx !== f[c / CPB] || tx_ready !== 1'b0) begin
        fails++;
        $display("FAIL cfg_change_frame cycle %0d: tx=%b ready=%b, expected tx=%b ready=0", c, tx, tx_ready, f[c / CPB]);
      end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if (tx_ready !== 1'b1 || tx !== 1'b1) begin
        fails++;
        $display("FAIL cfg_change_idle cycle %0d: ready=%b tx=%b, expected 1 1", c, tx_ready, tx);
      end
    end
    parity_en = 1'b0; parity_even_n = 1'b0; stop2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tx_data = 8'h00; tx_valid = 1'b0;
    parity_en = 1'b0; parity_even_n = 1'b0; stop2 = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_two_stop();
    test_back_to_back();
    test_reset_mid_frame();
    test_config_change();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
